dit_result_serializer: RTL and testbench

//  Receiving end of the dit FFT result interface. On the done1 pulse, captures
//  the 16 parallel result words a2..p2 and streams them out one word per beat

---
 rtl/dit_result_serializer.sv | 167 ++++++++++++++++
 tb/tb_dit_result_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dit_result_serializer.sv
// Captures the 16 dit result words on done1 and streams them out over valid/ready, word 0 first.
// Optional: define FFT_SER_OVF_EN to add the sticky ovf flag and a 4-bit saturating drop counter.
module dit_result_serializer #(
  parameter int DATA_W     = 17,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              done1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] c2,
  input  logic [DATA_W-1:0] d2,
  input  logic [DATA_W-1:0] e2,
  input  logic [DATA_W-1:0] f2,
  input  logic [DATA_W-1:0] g2,
  input  logic [DATA_W-1:0] h2,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] j2,
  input  logic [DATA_W-1:0] k2,
  input  logic [DATA_W-1:0] l2,
  input  logic [DATA_W-1:0] m2,
  input  logic [DATA_W-1:0] n2,
  input  logic [DATA_W-1:0] o2,
  input  logic [DATA_W-1:0] p2,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic       GAP_EN   = (GAP_CYCLES != 0);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t            state_q;
  logic [DATA_W-1:0] out_data_q;
  logic [3:0]        out_index_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [3:0]        gap_cnt_q;

  logic [DATA_W-1:0] in_words [16];
  logic [DATA_W-1:0] frame_q  [16];

  logic accept;
  logic last_accept;
  logic capture;

  assign in_words[0]  = a2;
  assign in_words[1]  = b2;
  assign in_words[2]  = c2;
  assign in_words[3]  = d2;
  assign in_words[4]  = e2;
  assign in_words[5]  = f2;
  assign in_words[6]  = g2;
  assign in_words[7]  = h2;
  assign in_words[8]  = i2;
  assign in_words[9]  = j2;
  assign in_words[10] = k2;
  assign in_words[11] = l2;
  assign in_words[12] = m2;
  assign in_words[13] = n2;
  assign in_words[14] = o2;
  assign in_words[15] = p2;

  assign accept      = out_valid_q && out_ready;
  assign last_accept = (state_q == SEND) && accept && out_last_q;
  // With no gap, the final accept frees the frame register in the same cycle.
  assign busy        = (state_q != IDLE) && !(last_accept && !GAP_EN);
  assign capture     = done1 && !busy && !reset;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_frame
      always_ff @(posedge clk) begin
        if (capture) begin
          frame_q[gi] <= in_words[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      gap_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (done1) begin
            state_q     <= SEND;
            out_data_q  <= a2;
            out_index_q <= 4'd0;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        SEND: begin
          if (accept) begin
            if (out_last_q) begin
              out_index_q <= 4'd0;
              out_last_q  <= 1'b0;
              if (GAP_EN) begin
                state_q     <= GAP;
                out_valid_q <= 1'b0;
                gap_cnt_q   <= GAP_LOAD;
              end else if (done1) begin
                out_data_q  <= a2;
                out_valid_q <= 1'b1;
              end else begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
              end
            end else begin
              out_index_q <= out_index_q + 4'd1;
              out_data_q  <= frame_q[out_index_q + 4'd1];
              out_last_q  <= (out_index_q == 4'd14);
            end
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

`ifdef FFT_SER_OVF_EN
  logic       ovf_q;
  logic [3:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (done1 && busy) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != 4'd15) begin
        drop_cnt_q <= drop_cnt_q + 4'd1;
      end
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_dit_result_serializer.sv
// Directed bench for dit_result_serializer: a GAP_CYCLES=0 instance plus a GAP_CYCLES=3 instance on shared inputs.
module tb_dit_result_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        done1;
  logic        out_ready;
  logic [16:0] tb_w [16];
  logic [16:0] fa [16];
  logic [16:0] fb [16];
  logic [16:0] fd [16];
  logic [16:0] fe [16];

  logic [16:0] o_data,  g_data;
  logic [3:0]  o_index, g_index;
  logic        o_valid, g_valid;
  logic        o_last,  g_last;
  logic        o_busy,  g_busy;
  logic        o_ovf,   g_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dit_result_serializer #(.DATA_W(17), .GAP_CYCLES(0)) dut (
    .clk(clk), .reset(reset), .done1(done1),
    .a2(tb_w[0]), .b2(tb_w[1]), .c2(tb_w[2]), .d2(tb_w[3]),
    .e2(tb_w[4]), .f2(tb_w[5]), .g2(tb_w[6]), .h2(tb_w[7]),
    .i2(tb_w[8]), .j2(tb_w[9]), .k2(tb_w[10]), .l2(tb_w[11]),
    .m2(tb_w[12]), .n2(tb_w[13]), .o2(tb_w[14]), .p2(tb_w[15]),
    .out_data(o_data), .out_index(o_index), .out_valid(o_valid),
    .out_ready(out_ready), .out_last(o_last), .busy(o_busy), .ovf(o_ovf)
  );

  dit_result_serializer #(.DATA_W(17), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .reset(reset), .done1(done1),
    .a2(tb_w[0]), .b2(tb_w[1]), .c2(tb_w[2]), .d2(tb_w[3]),
    .e2(tb_w[4]), .f2(tb_w[5]), .g2(tb_w[6]), .h2(tb_w[7]),
    .i2(tb_w[8]), .j2(tb_w[9]), .k2(tb_w[10]), .l2(tb_w[11]),
    .m2(tb_w[12]), .n2(tb_w[13]), .o2(tb_w[14]), .p2(tb_w[15]),
    .out_data(g_data), .out_index(g_index), .out_valid(g_valid),
    .out_ready(out_ready), .out_last(g_last), .busy(g_busy), .ovf(g_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] word(input int sel, input int i);
    case (sel)
      0:       return fa[i];
      1:       return fb[i];
      2:       return fd[i];
      default: return fe[i];
    endcase
  endfunction

  task automatic load(input int sel);
    for (int i = 0; i < 16; i++) tb_w[i] = word(sel, i);
  endtask

  task automatic pulse();
    done1 = 1'b1;
    step();
    done1 = 1'b0;
  endtask

  // Checks the currently presented beat of the GAP_CYCLES=0 instance.
  task automatic beat(input string tag, input int sel, input int i);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_index"}, 32'(o_index), 32'(i));
    check({tag, "_data"},  32'(o_data),  32'(word(sel, i)));
    check({tag, "_last"},  32'(o_last),  32'(i == 15));
  endtask

  initial begin
    int exp_idx;
    int cyc;
    fa[0] = 17'd1853; fa[1] = 17'd1156; fa[2]  = 17'd6758; fa[3]  = 17'd6785;
    fa[4] = 17'd5678; fa[5] = 17'd1056; fa[6]  = 17'd6787; fa[7]  = 17'd1125;
    fa[8] = 17'd112;  fa[9] = 17'd139;  fa[10] = 17'd174;  fa[11] = 17'd252;
    fa[12] = 17'd249; fa[13] = 17'd280; fa[14] = 17'd300;  fa[15] = 17'd252;
    for (int i = 0; i < 16; i++) begin
      fb[i] = fa[8 + (i % 8)];
      fd[i] = fa[i] ^ 17'h10000;
      fe[i] = 17'h1FFFF - 17'(i * 4099);
    end

    // T1: reset held 3 cycles with done1 asserted
    reset = 1'b1; done1 = 1'b1; out_ready = 1'b1; load(0);
    repeat (3) step();
    check("t1_valid", 32'(o_valid), 32'd0);
    check("t1_data",  32'(o_data),  32'd0);
    check("t1_index", 32'(o_index), 32'd0);
    check("t1_last",  32'(o_last),  32'd0);
    check("t1_busy",  32'(o_busy),  32'd0);
    check("t1_ovf",   32'(o_ovf),   32'd0);
    reset = 1'b0; done1 = 1'b0;
    step();
    check("t1_post_valid", 32'(o_valid), 32'd0);
    $display("T1 reset done");

    // T2: single frame, ready high; gap instance checked for 3 busy cycles
    pulse();
    check("t2_g_data0", 32'(g_data), 32'(fa[0]));
    for (int i = 0; i < 16; i++) begin
      beat("t2", 0, i);
      if (i == 15) begin
        check("t2_busy_last",   32'(o_busy), 32'd0);
        check("t2_g_busy_last", 32'(g_busy), 32'd1);
      end
      step();
    end
    check("t2_valid_after", 32'(o_valid), 32'd0);
    check("t2_busy_after",  32'(o_busy),  32'd0);
    for (int k = 0; k < 3; k++) begin
      check("t2_g_gap_busy", 32'(g_busy), 32'd1);
      step();
    end
    check("t2_g_gap_end", 32'(g_busy), 32'd0);
    $display("T2 single frame done");
    repeat (3) step();

    // T3: random backpressure
    pulse();
    exp_idx = 0; cyc = 0;
    while (exp_idx < 16 && cyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      check("t3_valid", 32'(o_valid), 32'd1);
      check("t3_index", 32'(o_index), 32'(exp_idx));
      check("t3_data",  32'(o_data),  32'(fa[exp_idx]));
      if (out_ready) exp_idx++;
      step();
      cyc++;
    end
    check("t3_complete", 32'(exp_idx), 32'd16);
    out_ready = 1'b1;
    check("t3_valid_after", 32'(o_valid), 32'd0);
    $display("T3 backpressure done in %0d cycles", cyc);
    repeat (6) step();

    // T4: back-to-back frames with done1 on the index-15 accept
    pulse();
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        load(1);
        done1 = 1'b1;
        check("t4_busy_b2b", 32'(o_busy), 32'd0);
      end
      beat("t4a", 0, i);
      step();
    end
    done1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      beat("t4b", 1, i);
      step();
    end
    check("t4_valid_after", 32'(o_valid), 32'd0);
    $display("T4 back-to-back done");
    repeat (6) step();

    // T5: done1 mid-frame with different data is dropped
    check("t5_ovf_before", 32'(o_ovf), 32'd0);
    load(0);
    pulse();
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        load(2);
        done1 = 1'b1;
        check("t5_busy_drop", 32'(o_busy), 32'd1);
      end
      beat("t5", 0, i);
      step();
      done1 = 1'b0;
    end
`ifdef FFT_SER_OVF_EN
    check("t5_ovf", 32'(o_ovf), 32'd1);
    check("t5_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    // Hold done1 against a stalled frame to saturate the drop counter.
    out_ready = 1'b0;
    load(0);
    pulse();
    done1 = 1'b1;
    repeat (20) step();
    done1 = 1'b0;
    check("t5_drop_sat", 32'(dut.drop_cnt_q), 32'd15);
    check("t5_hold_data", 32'(o_data), 32'(fa[0]));
    out_ready = 1'b1;
`else
    check("t5_ovf", 32'(o_ovf), 32'd0);
`endif
    $display("T5 drop done");

    // T6: reset mid-frame at index 7, then a fresh frame
    load(0);
    reset = 1'b1; step(); reset = 1'b0;
    pulse();
    for (int i = 0; i < 7; i++) begin
      beat("t6a", 0, i);
      step();
    end
    beat("t6a", 0, 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_index", 32'(o_index), 32'd0);
    check("t6_rst_data",  32'(o_data),  32'd0);
    check("t6_rst_busy",  32'(o_busy),  32'd0);
    check("t6_rst_ovf",   32'(o_ovf),   32'd0);
    step();
    check("t6_no_partial", 32'(o_valid), 32'd0);
    load(3);
    pulse();
    for (int i = 0; i < 16; i++) begin
      beat("t6b", 3, i);
      step();
    end
    check("t6_valid_after", 32'(o_valid), 32'd0);
    $display("T6 reset mid-frame done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
